laser_controller: RTL and testbench

Player-side laser generator for the game datapath. It turns the fire button and the player ship's horizontal position into a single travelling laser beam, `laser_h`/`laser_v`/`laser_enable`. It terminates the beam on a lane hit reported back by the enemy controller (`attack_valid`/`attack_v`) or when the beam reaches the top of the screen. It also keeps a hit counter for the score logic.

---
 rtl/laser_controller.sv | 114 +++++++++++
 tb/tb_laser_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_controller.sv
// Player laser generator: launch on fire, rise each clock, end on hit or top-out.
// Optional LASER_AUTOFIRE_EN: a held fire button relaunches after every cooldown.
module laser_controller #(
  parameter int LASER_START_V  = 400,
  parameter int LASER_STEP     = 4,
  parameter int LASER_H_OFFSET = 10,
  parameter int COOLDOWN       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  input  logic       fire,
  input  logic [9:0] player_h,
  input  logic [3:0] attack_valid,
  input  logic [9:0] attack_v,
  output logic [9:0] laser_h,
  output logic [9:0] laser_v,
  output logic       laser_enable,
  output logic       hit_pulse,
  output logic [7:0] hit_count
);

  localparam int CD = (COOLDOWN < 1) ? 1 : COOLDOWN;
  localparam int CW = $clog2(CD + 1);
  localparam logic [CW-1:0] CD_V  = CW'(CD);
  localparam logic [CW-1:0] ONE_V = CW'(1);
  localparam logic [9:0] START_V  = 10'(LASER_START_V);
  localparam logic [9:0] STEP_V   = 10'(LASER_STEP);
  localparam logic [9:0] OFS_V    = 10'(LASER_H_OFFSET);

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    COOL
  } fsm_t;

  fsm_t          fsm;
  logic          fire_q;
  logic [CW-1:0] cnt;
  logic          trig;
  logic          hit;

`ifdef LASER_AUTOFIRE_EN
  assign trig = fire;
`else
  assign trig = fire & ~fire_q;
`endif

  // Same kill condition the enemy controller applies to its lane.
  assign hit = (attack_valid < 4'd8) && (attack_v >= 10'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm          <= IDLE;
      fire_q       <= 1'b0;
      cnt          <= '0;
      laser_h      <= '0;
      laser_v      <= '0;
      laser_enable <= 1'b0;
      hit_pulse    <= 1'b0;
      hit_count    <= '0;
    end else if (state == 2'd0) begin
      fsm          <= IDLE;
      fire_q       <= 1'b0;
      cnt          <= '0;
      laser_h      <= '0;
      laser_v      <= '0;
      laser_enable <= 1'b0;
      hit_pulse    <= 1'b0;
      hit_count    <= '0;
    end else begin
      fire_q    <= fire;
      hit_pulse <= 1'b0;
      if (state == 2'd1) begin
        unique case (fsm)
          IDLE: begin
            if (trig) begin
              fsm          <= FLY;
              laser_enable <= 1'b1;
              laser_h      <= player_h + OFS_V;
              laser_v      <= START_V;
            end
          end
          FLY: begin
            if (hit) begin
              fsm          <= COOL;
              laser_enable <= 1'b0;
              hit_pulse    <= 1'b1;
              cnt          <= CD_V;
              if (hit_count != 8'hFF)
                hit_count <= hit_count + 8'd1;
            end else if (laser_v < STEP_V) begin
              fsm          <= COOL;
              laser_enable <= 1'b0;
              cnt          <= CD_V;
            end else begin
              laser_v <= laser_v - STEP_V;
            end
          end
          COOL: begin
            if (cnt == ONE_V) begin
              fsm <= IDLE;
              cnt <= '0;
            end else begin
              cnt <= cnt - ONE_V;
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_laser_controller.sv
// Random and directed stimulus for laser_controller against a behavioural beam model.
module tb_laser_controller;

`ifdef LASER_AUTOFIRE_EN
  localparam bit AF = 1'b1;
`else
  localparam bit AF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state = 2'd0;
  logic       fire = 1'b0;
  logic [9:0] player_h = '0;
  logic [3:0] attack_valid = 4'd8;
  logic [9:0] attack_v = '0;
  logic [9:0] laser_h;
  logic [9:0] laser_v;
  logic       laser_enable;
  logic       hit_pulse;
  logic [7:0] hit_count;

  int total = 0;
  int bad = 0;

  // beam model: a beam is either flying, cooling down, or waiting
  bit m_on;
  int m_cool;
  int m_h, m_v, m_hits;
  bit m_pulse, m_fq;

  laser_controller dut (
    .clk(clk),
    .rst_n(rst_n),
    .state(state),
    .fire(fire),
    .player_h(player_h),
    .attack_valid(attack_valid),
    .attack_v(attack_v),
    .laser_h(laser_h),
    .laser_v(laser_v),
    .laser_enable(laser_enable),
    .hit_pulse(hit_pulse),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_on = 0; m_cool = 0; m_h = 0; m_v = 0;
    m_hits = 0; m_pulse = 0; m_fq = 0;
  endtask

  task automatic model_step();
    bit launch;
    if (state == 2'd0) begin
      m_clear();
      return;
    end
    launch = fire && (AF || !m_fq);
    m_fq = fire;
    m_pulse = 0;
    if (state != 2'd1) return;
    if (m_on) begin
      if (attack_valid < 8 && attack_v >= 10) begin
        m_on = 0;
        m_pulse = 1;
        m_hits = (m_hits == 255) ? 255 : m_hits + 1;
        m_cool = 16;
      end else if (m_v < 4) begin
        m_on = 0;
        m_cool = 16;
      end else begin
        m_v = m_v - 4;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (launch) begin
      m_on = 1;
      m_h = (int'(player_h) + 10) % 1024;
      m_v = 400;
    end
  endtask

  task automatic compare_all();
    check("laser_h", int'(laser_h), m_h);
    check("laser_v", int'(laser_v), m_v);
    check("laser_enable", int'(laser_enable), int'(m_on));
    check("hit_pulse", int'(hit_pulse), int'(m_pulse));
    check("hit_count", int'(hit_count), m_hits);
  endtask

  // inputs are set at a negedge; model and DUT both see them at the next posedge
  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic launch_beam(input logic [9:0] ph);
    player_h = ph;
    fire = 1'b1;
    cycle();
    fire = 1'b0;
  endtask

  task automatic idle_wait();
    int guard = 0;
    attack_valid = 4'd8;
    while ((m_on || m_cool > 0) && guard < 200) begin
      cycle();
      guard++;
    end
    check("idle_wait_timeout", guard < 200, 1);
  endtask

  initial begin
    int en_cycles, launches, r;
    bit prev_en;
    m_clear();
    #17;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    state = 2'd1;
    cycle();

    // miss: full flight, then cooldown blocks relaunch
    launch_beam(10'd100);
    check("miss_h", int'(laser_h), 110);
    en_cycles = 1;
    for (int i = 0; i < 120; i++) begin
      cycle();
      if (laser_enable) en_cycles++;
    end
    check("miss_len", en_cycles, 101);
    check("miss_hits", int'(hit_count), 0);
    idle_wait();

    // hit with attack_v=5 is ignored, attack_v=50 kills
    launch_beam(10'd1020);
    check("wrap_h", int'(laser_h), 6);
    cycles(3);
    attack_valid = 4'd2; attack_v = 10'd5;
    cycle();
    check("low_v_nohit", int'(laser_enable), 1);
    attack_v = 10'd50;
    cycle();
    check("hit_en", int'(laser_enable), 0);
    check("hit_pulse1", int'(hit_pulse), 1);
    check("hit_cnt1", int'(hit_count), 1);
    attack_valid = 4'd8;
    cycle();
    check("hit_pulse_clr", int'(hit_pulse), 0);
    idle_wait();

    // hit and top-out together at laser_v=0
    launch_beam(10'd200);
    cycles(100);
    check("top_v0", int'(laser_v), 0);
    attack_valid = 4'd7; attack_v = 10'd10;
    cycle();
    check("top_hit", int'(hit_count), 2);
    idle_wait();

    // freeze at laser_v=300
    launch_beam(10'd300);
    cycles(25);
    state = 2'd2;
    fire = 1'b1;
    cycles(20);
    check("freeze_v", int'(laser_v), 300);
    fire = 1'b0;
    state = 2'd1;
    cycle();
    check("resume_v", int'(laser_v), 296);
    state = 2'd0;
    cycle();
    check("clear_en", int'(laser_enable), 0);
    check("clear_cnt", int'(hit_count), 0);
    state = 2'd1;

    // held fire
    fire = 1'b1;
    launches = 0;
    prev_en = 0;
    for (int i = 0; i < 250; i++) begin
      cycle();
      if (laser_enable && !prev_en) launches++;
      prev_en = laser_enable;
    end
    check("held_multi", int'(launches > 1), int'(AF));
    fire = 1'b0;
    idle_wait();

    // saturation
    for (int k = 0; k < 258; k++) begin
      launch_beam(10'(k));
      attack_valid = 4'(k % 8); attack_v = 10'd500;
      cycle();
      idle_wait();
    end
    check("sat", int'(hit_count), 255);

    // random play
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      state = (r < 92) ? 2'd1 : (r < 99) ? 2'(2 + $urandom_range(0, 1)) : 2'd0;
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      player_h = 10'($urandom);
      attack_valid = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 8)) : 4'd8;
      attack_v = 10'($urandom_range(0, 31));
      cycle();
    end

    // reset mid-flight
    state = 2'd1; fire = 1'b0; attack_valid = 4'd8;
    idle_wait();
    cycle();
    launch_beam(10'd50);
    cycles(50);
    check("pre_rst_v", int'(laser_v), 200);
    #2;
    rst_n = 1'b0;
    #1;
    m_clear();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    launch_beam(10'd0);
    check("post_rst_launch", int'(laser_v), 400);
    cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
